// File: rtl/seq_pattern_check.sv
// Stream checker for the pattern test path: locks to the first accepted word,
// then verifies each following word is the previous one plus one, modulo 2^DataBits.
module seq_pattern_check #(
    parameter int DataBits  = 16,
    parameter int CountBits = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [DataBits-1:0]  din_data,
    output logic                 locked,
    output logic                 err_flag,
    output logic [CountBits-1:0] word_count,
    output logic [CountBits-1:0] err_count,
    output logic [CountBits-1:0] first_err_index,
    output logic [DataBits-1:0]  first_err_expected,
    output logic [DataBits-1:0]  first_err_actual
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    localparam logic [DataBits-1:0]  DataOne  = 1;
    localparam logic [CountBits-1:0] CountOne = 1;
    localparam logic [CountBits-1:0] CountMax = '1;

    logic [0:0]           r_state;
    logic [DataBits-1:0]  r_expected;
    logic                 r_errFlag;
    logic [CountBits-1:0] r_wordCount;
    logic [CountBits-1:0] r_errCount;
    logic [CountBits-1:0] r_firstErrIndex;
    logic [DataBits-1:0]  r_firstErrExpected;
    logic [DataBits-1:0]  r_firstErrActual;

    logic                 w_xfer;
    logic                 w_mismatch;
    logic [CountBits-1:0] w_wordCountInc;
    logic [CountBits-1:0] w_errCountInc;

    assign din_ready  = enable;
    assign w_xfer     = din_valid & enable;
    assign w_mismatch = (din_data != r_expected);

    // Counters stick at all-ones instead of wrapping.
    assign w_wordCountInc = (r_wordCount == CountMax) ? r_wordCount : r_wordCount + CountOne;
    assign w_errCountInc  = (r_errCount  == CountMax) ? r_errCount  : r_errCount  + CountOne;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state            <= ST_UNLOCKED;
            r_expected         <= '0;
            r_errFlag          <= 1'b0;
            r_wordCount        <= '0;
            r_errCount         <= '0;
            r_firstErrIndex    <= '0;
            r_firstErrExpected <= '0;
            r_firstErrActual   <= '0;
        end else if (w_xfer) begin
            r_wordCount <= w_wordCountInc;
            // On a match din_data equals expected, so din_data+1 covers both
            // the normal advance and the resync after a mismatch.
            r_expected  <= din_data + DataOne;
            if (r_state == ST_UNLOCKED) begin
                r_state <= ST_LOCKED;
            end else if (w_mismatch) begin
                r_errCount <= w_errCountInc;
                if (!r_errFlag) begin
                    r_errFlag          <= 1'b1;
                    r_firstErrIndex    <= r_wordCount;
                    r_firstErrExpected <= r_expected;
                    r_firstErrActual   <= din_data;
                end
            end
        end
    end

    assign locked             = (r_state == ST_LOCKED);
    assign err_flag           = r_errFlag;
    assign word_count         = r_wordCount;
    assign err_count          = r_errCount;
    assign first_err_index    = r_firstErrIndex;
    assign first_err_expected = r_firstErrExpected;
    assign first_err_actual   = r_firstErrActual;

endmodule

// File: tb/tb_seq_pattern_check.sv
// Self-checking bench for seq_pattern_check: directed scenarios plus a randomized
// stream compared against a model built from the list of accepted words.
module tb_seq_pattern_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic        din_valid;
    logic [15:0] din_data;

    logic        din_ready,  locked,  err_flag;
    logic [31:0] word_count, err_count, first_err_index;
    logic [15:0] first_err_expected, first_err_actual;

    logic        din_ready3, locked3, err_flag3;
    logic [2:0]  word_count3, err_count3, first_err_index3;
    logic [15:0] first_err_expected3, first_err_actual3;

    int checks   = 0;
    int failures = 0;

    // Every word accepted since the last reset/clear, in arrival order.
    logic [15:0] accepted[$];

    seq_pattern_check #(.DataBits(16), .CountBits(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .locked(locked), .err_flag(err_flag), .word_count(word_count),
        .err_count(err_count), .first_err_index(first_err_index),
        .first_err_expected(first_err_expected), .first_err_actual(first_err_actual)
    );

    seq_pattern_check #(.DataBits(16), .CountBits(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .din_valid(din_valid), .din_ready(din_ready3), .din_data(din_data),
        .locked(locked3), .err_flag(err_flag3), .word_count(word_count3),
        .err_count(err_count3), .first_err_index(first_err_index3),
        .first_err_expected(first_err_expected3), .first_err_actual(first_err_actual3)
    );

    always #5 clk = ~clk;

    // A word is in error when it is not the previous accepted word plus one.
    function automatic longint modelErrs();
        longint n = 0;
        for (int i = 1; i < accepted.size(); i++)
            if (accepted[i] != 16'(accepted[i-1] + 16'd1)) n++;
        return n;
    endfunction

    function automatic int modelFirstErr();
        for (int i = 1; i < accepted.size(); i++)
            if (accepted[i] != 16'(accepted[i-1] + 16'd1)) return i;
        return -1;
    endfunction

    function automatic longint sat(input longint v, input int bits);
        longint m = (longint'(1) << bits) - 1;
        return (v > m) ? m : v;
    endfunction

    // One clock with the given inputs; the model follows the same edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic clr);
        din_valid = v;
        din_data  = d;
        clear     = clr;
        @(posedge clk);
        if (!rst_n || clr) accepted.delete();
        else if (enable && v) accepted.push_back(d);
        #1;
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    // Random idle gap, then one transfer.
    task automatic applyStimulus(input logic [15:0] d);
        repeat ($urandom_range(0, 2)) cycle(1'b0, 16'($urandom), 1'b0);
        cycle(1'b1, d, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b1, 16'h5555, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
        checks++;
        if ({locked, err_flag, word_count, err_count, first_err_index,
             first_err_expected, first_err_actual} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got lk=%b ef=%b wc=%0d ec=%0d, need all 0",
                     locked, err_flag, word_count, err_count);
        end
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b, need 1", din_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_increment();
        cycle(1'b0, 16'h0000, 1'b1);
        applyStimulus(16'h1234);
        checks++;
        if (locked !== 1'b1 || word_count !== 32'd1) begin
            failures++;
            $display("[TB] FAIL first_lock: got lk=%b wc=%0d, need lk=1 wc=1", locked, word_count);
        end
        for (int i = 1; i < 10; i++) applyStimulus(16'h1234 + 16'(i));
        checks++;
        if (word_count !== 32'd10 || err_count !== 32'd0 || err_flag !== 1'b0) begin
            failures++;
            $display("[TB] FAIL increment: got wc=%0d ec=%0d ef=%b, need 10 0 0",
                     word_count, err_count, err_flag);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 16'h0000, 1'b1);
        applyStimulus(16'hFFFE);
        applyStimulus(16'hFFFF);
        applyStimulus(16'h0000);
        applyStimulus(16'h0001);
        checks++;
        if (word_count !== 32'd4 || err_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL wrap: got wc=%0d ec=%0d, need 4 0", word_count, err_count);
        end
    endtask

    task automatic test_dropped();
        cycle(1'b0, 16'h0000, 1'b1);
        applyStimulus(16'd5);
        applyStimulus(16'd6);
        applyStimulus(16'd8);
        applyStimulus(16'd9);
        checks++;
        if (err_count !== 32'd1 || err_flag !== 1'b1 || first_err_index !== 32'd2 ||
            first_err_expected !== 16'd7 || first_err_actual !== 16'd8) begin
            failures++;
            $display("[TB] FAIL dropped: got ec=%0d ef=%b cap=(%0d,%h,%h), need 1 1 (2,0007,0008)",
                     err_count, err_flag, first_err_index, first_err_expected, first_err_actual);
        end
    endtask

    task automatic test_corrupted();
        cycle(1'b0, 16'h0000, 1'b1);
        applyStimulus(16'd5);
        applyStimulus(16'd6);
        applyStimulus(16'h0099);
        checks++;
        if (first_err_index !== 32'd2 || first_err_expected !== 16'd7 ||
            first_err_actual !== 16'h0099) begin
            failures++;
            $display("[TB] FAIL corrupt_capture: got (%0d,%h,%h), need (2,0007,0099)",
                     first_err_index, first_err_expected, first_err_actual);
        end
        applyStimulus(16'd8);
        applyStimulus(16'd9);
        checks++;
        if (err_count !== 32'd2 || word_count !== 32'd5 || first_err_index !== 32'd2 ||
            first_err_expected !== 16'd7 || first_err_actual !== 16'h0099) begin
            failures++;
            $display("[TB] FAIL corrupt_final: got ec=%0d wc=%0d cap=(%0d,%h,%h), need 2 5 (2,0007,0099)",
                     err_count, word_count, first_err_index, first_err_expected, first_err_actual);
        end
    endtask

    task automatic test_saturation();
        cycle(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus((i % 2 == 0) ? 16'h0000 : 16'h00FF);
        checks++;
        if (word_count3 !== 3'd7 || err_count3 !== 3'd7 || first_err_index3 !== 3'd1) begin
            failures++;
            $display("[TB] FAIL saturate: got wc=%0d ec=%0d idx=%0d, need 7 7 1",
                     word_count3, err_count3, first_err_index3);
        end
        checks++;
        if (locked3 !== 1'b1 || err_flag3 !== 1'b1 || din_ready3 !== 1'b1 ||
            first_err_expected3 !== 16'h0001 || first_err_actual3 !== 16'h00FF) begin
            failures++;
            $display("[TB] FAIL saturate_capture: got lk=%b ef=%b rdy=%b exp=%h act=%h, need 1 1 1 0001 00FF",
                     locked3, err_flag3, din_ready3, first_err_expected3, first_err_actual3);
        end
        checks++;
        if (word_count !== 32'd12 || err_count !== 32'd11) begin
            failures++;
            $display("[TB] FAIL no_saturate_wide: got wc=%0d ec=%0d, need 12 11", word_count, err_count);
        end
    endtask

    task automatic test_enable();
        cycle(1'b0, 16'h0000, 1'b1);
        applyStimulus(16'h0100);
        applyStimulus(16'h0101);
        enable = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_ready: got %b, need 0", din_ready);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0F00 + 16'(i), 1'b0);
        checks++;
        if (word_count !== 32'd2 || err_count !== 32'd0 || din_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_frozen: got wc=%0d ec=%0d rdy=%b, need 2 0 0",
                     word_count, err_count, din_ready);
        end
        enable = 1'b1;
        applyStimulus(16'h0102);
        checks++;
        if (word_count !== 32'd3 || err_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL enable_resume: got wc=%0d ec=%0d, need 3 0", word_count, err_count);
        end
    endtask

    task automatic test_clear();
        cycle(1'b0, 16'h0000, 1'b1);
        applyStimulus(16'h0200);
        applyStimulus(16'h0300);
        cycle(1'b1, 16'h0301, 1'b1);
        checks++;
        if (word_count !== 32'd0 || locked !== 1'b0 || err_flag !== 1'b0 || err_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL clear_xfer: got wc=%0d lk=%b ef=%b ec=%0d, need 0 0 0 0",
                     word_count, locked, err_flag, err_count);
        end
        applyStimulus(16'h7000);
        applyStimulus(16'h7001);
        checks++;
        if (word_count !== 32'd2 || err_count !== 32'd0 || locked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clear_relock: got wc=%0d ec=%0d lk=%b, need 2 0 1",
                     word_count, err_count, locked);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b0, 16'h0000, 1'b1);
        applyStimulus(16'h0010);
        applyStimulus(16'h0020);
        rst_n = 1'b0;
        cycle(1'b1, 16'h0021, 1'b0);
        checks++;
        if ({locked, err_flag, word_count, err_count, first_err_index,
             first_err_expected, first_err_actual} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset: got lk=%b ef=%b wc=%0d ec=%0d idx=%0d, need all 0",
                     locked, err_flag, word_count, err_count, first_err_index);
        end
        rst_n = 1'b1;
        applyStimulus(16'h4000);
        applyStimulus(16'h4001);
        checks++;
        if (word_count !== 32'd2 || err_count !== 32'd0 || locked !== 1'b1 || err_flag !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_relock: got wc=%0d ec=%0d lk=%b ef=%b, need 2 0 1 0",
                     word_count, err_count, locked, err_flag);
        end
    endtask

    task automatic test_random();
        logic [15:0] next;
        int first;
        cycle(1'b0, 16'h0000, 1'b1);
        next = 16'($urandom);
        for (int n = 0; n < 400; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 14) == 0) next = 16'($urandom);
            cycle(($urandom_range(0, 2) != 0), next, 1'b0);
            if (accepted.size() > 0 && accepted[accepted.size()-1] == next) next = next + 16'd1;
            checks++;
            if (word_count !== 32'(accepted.size()) || err_count !== 32'(modelErrs()) ||
                word_count3 !== 3'(sat(accepted.size(), 3)) || err_count3 !== 3'(sat(modelErrs(), 3))) begin
                failures++;
                $display("[TB] FAIL random_counts: step %0d got wc=%0d ec=%0d wc3=%0d ec3=%0d, need %0d %0d %0d %0d",
                         n, word_count, err_count, word_count3, err_count3, accepted.size(),
                         modelErrs(), sat(accepted.size(), 3), sat(modelErrs(), 3));
            end
        end
        enable = 1'b1;
        first = modelFirstErr();
        checks++;
        if (first < 0) begin
            if (err_flag !== 1'b0) begin
                failures++;
                $display("[TB] FAIL random_flag: got %b, need 0", err_flag);
            end
        end else if (err_flag !== 1'b1 || first_err_index !== 32'(first) ||
                     first_err_expected !== 16'(accepted[first-1] + 16'd1) ||
                     first_err_actual !== accepted[first] ||
                     first_err_index3 !== 3'(sat(first, 3))) begin
            failures++;
            $display("[TB] FAIL random_capture: got ef=%b (%0d,%h,%h) idx3=%0d, need 1 (%0d,%h,%h) %0d",
                     err_flag, first_err_index, first_err_expected, first_err_actual, first_err_index3,
                     first, 16'(accepted[first-1] + 16'd1), accepted[first], sat(first, 3));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        din_valid = 1'b0;
        din_data  = 16'h0000;
        #2;
        test_reset();
        test_increment();
        test_wrap();
        test_dropped();
        test_corrupted();
        test_saturation();
        test_enable();
        test_clear();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
